// File: rtl/lut_interp_pkg.sv
// Shared definitions for the breakpoint-table interpolation controller:
// default table geometry and the controller state encoding.
package lut_interp_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_POINTS = 8;
    localparam int DEF_ADDR_W     = $clog2(DEF_NUM_POINTS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/lut_interp_if.sv
// Bundle of the configuration, query and result signals of lut_interp_ctrl.
//   master : the side that loads breakpoints, issues queries, accepts results
//   slave  : the controller side
interface lut_interp_if
    import lut_interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W
) ();

    logic                  cfg_we;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_x;
    logic [DATA_WIDTH-1:0] cfg_y;
    logic                  cfg_busy;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_x;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_y;
    logic                  out_clamped;

    modport master (
        output cfg_we, cfg_addr, cfg_x, cfg_y, in_valid, in_x, out_ready,
        input  cfg_busy, in_ready, out_valid, out_y, out_clamped
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_x, cfg_y, in_valid, in_x, out_ready,
        output cfg_busy, in_ready, out_valid, out_y, out_clamped
    );

endinterface

// File: rtl/linear_interpolation.sv
// Combinational linear interpolation between (x0,y0) and (x1,y1) at x.
// All values unsigned DATA_WIDTH; y may fall or rise across the segment.
//   x0, y0, x1, y1 : segment end points
//   x              : abscissa, expected inside [x0, x1]
//   y              : interpolated ordinate, truncated toward y0
module linear_interpolation #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] x1,
    input  logic [DATA_WIDTH-1:0] y1,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] dy;
    logic [DATA_WIDTH-1:0] dx;
    logic [DATA_WIDTH-1:0] span;
    logic [PW-1:0]         prod;
    logic [DATA_WIDTH-1:0] step;
    logic                  rising;

    always_comb begin
        rising = (y1 >= y0);
        dy     = rising ? (y1 - y0) : (y0 - y1);
        dx     = x - x0;
        span   = x1 - x0;
        prod   = {{DATA_WIDTH{1'b0}}, dy} * {{DATA_WIDTH{1'b0}}, dx};
        step   = '0;
        y      = y0;
        // A zero-width segment has no slope: answer y0 rather than divide.
        // Out-of-segment x saturates to the nearer end point.
        if ((x1 == x0) || (x <= x0)) begin
            y = y0;
        end else if (x >= x1) begin
            y = y1;
        end else begin
            step = DATA_WIDTH'(prod / {{DATA_WIDTH{1'b0}}, span});
            y    = rising ? (y0 + step) : (y0 - step);
        end
    end

endmodule

// File: rtl/lut_interp_ctrl.sv
// Piecewise-linear lookup: NUM_POINTS programmable (x,y) breakpoints, one
// query in flight at a time, linear scan of segments then one interpolation.
//
//   state   | meaning
//   IDLE    | in_ready=1, table writable, waiting for a query
//   SEARCH  | scanning one breakpoint per cycle for the segment holding xc
//   COMPUTE | interpolating on segment idx, result registered into out_y
//   DONE    | out_valid=1, result held until out_ready
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cfg_we/cfg_addr/cfg_x/cfg_y      breakpoint write (honoured in IDLE only)
//   cfg_busy                         writes are being dropped
//   in_valid/in_ready/in_x           query handshake
//   out_valid/out_ready/out_y        result handshake
//   out_clamped                      query fell outside the table x range
module lut_interp_ctrl
    import lut_interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    localparam int ADDR_W    = $clog2(NUM_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_x,
    input  logic [DATA_WIDTH-1:0] cfg_y,
    output logic                  cfg_busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_clamped
);

    localparam logic [ADDR_W-1:0] LAST_SEG = ADDR_W'(NUM_POINTS - 2);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [DATA_WIDTH-1:0] xc_q, xc_d;
    logic                  clamped_q, clamped_d;
    logic [DATA_WIDTH-1:0] out_y_q, out_y_d;
    logic                  out_clamped_q, out_clamped_d;
    logic [DATA_WIDTH-1:0] tbl_x_q [NUM_POINTS];
    logic [DATA_WIDTH-1:0] tbl_x_d [NUM_POINTS];
    logic [DATA_WIDTH-1:0] tbl_y_q [NUM_POINTS];
    logic [DATA_WIDTH-1:0] tbl_y_d [NUM_POINTS];

    // A write arriving on the same edge as a query is parked here and lands
    // when that query retires, so the whole query sees the old table.
    logic                  pend_we_q, pend_we_d;
    logic [ADDR_W-1:0]     pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_x_q, pend_x_d;
    logic [DATA_WIDTH-1:0] pend_y_q, pend_y_d;

    logic [ADDR_W-1:0]     idx_nxt;
    logic                  cfg_addr_ok;
    logic [DATA_WIDTH-1:0] x_lo;
    logic [DATA_WIDTH-1:0] x_hi;
    logic [DATA_WIDTH-1:0] interp_y;

    assign idx_nxt     = idx_q + 1'b1;
    assign cfg_addr_ok = (int'(cfg_addr) < NUM_POINTS);
    assign x_lo        = tbl_x_q[0];
    assign x_hi        = tbl_x_q[NUM_POINTS-1];

    assign cfg_busy    = (state_q != IDLE);
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_y       = out_y_q;
    assign out_clamped = out_clamped_q;

    linear_interpolation #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_interp (
        .x0 (tbl_x_q[idx_q]),
        .y0 (tbl_y_q[idx_q]),
        .x1 (tbl_x_q[idx_nxt]),
        .y1 (tbl_y_q[idx_nxt]),
        .x  (xc_q),
        .y  (interp_y)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xc_d          = xc_q;
        clamped_d     = clamped_q;
        out_y_d       = out_y_q;
        out_clamped_d = out_clamped_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_x_d      = pend_x_q;
        pend_y_d      = pend_y_q;
        tbl_x_d       = tbl_x_q;
        tbl_y_d       = tbl_y_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEARCH;
                    idx_d   = '0;
                    if (in_x < x_lo) begin
                        xc_d      = x_lo;
                        clamped_d = 1'b1;
                    end else if (in_x > x_hi) begin
                        xc_d      = x_hi;
                        clamped_d = 1'b1;
                    end else begin
                        xc_d      = in_x;
                        clamped_d = 1'b0;
                    end
                    if (cfg_we && cfg_addr_ok) begin
                        pend_we_d   = 1'b1;
                        pend_addr_d = cfg_addr;
                        pend_x_d    = cfg_x;
                        pend_y_d    = cfg_y;
                    end
                end else if (cfg_we && cfg_addr_ok) begin
                    tbl_x_d[cfg_addr] = cfg_x;
                    tbl_y_d[cfg_addr] = cfg_y;
                end
            end
            SEARCH: begin
                // The last segment also catches xc == tbl_x[N-1].
                if ((xc_q < tbl_x_q[idx_nxt]) || (idx_q == LAST_SEG)) begin
                    state_d = COMPUTE;
                end else begin
                    idx_d = idx_nxt;
                end
            end
            COMPUTE: begin
                out_y_d       = interp_y;
                out_clamped_d = clamped_q;
                state_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (pend_we_q) begin
                        tbl_x_d[pend_addr_q] = pend_x_q;
                        tbl_y_d[pend_addr_q] = pend_y_q;
                        pend_we_d            = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            xc_q          <= '0;
            clamped_q     <= 1'b0;
            out_y_q       <= '0;
            out_clamped_q <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            tbl_x_q       <= '{default: '0};
            tbl_y_q       <= '{default: '0};
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xc_q          <= xc_d;
            clamped_q     <= clamped_d;
            out_y_q       <= out_y_d;
            out_clamped_q <= out_clamped_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            tbl_x_q       <= tbl_x_d;
            tbl_y_q       <= tbl_y_d;
        end
    end

endmodule

// File: tb/tb_lut_interp_ctrl.sv
// Bench for lut_interp_ctrl: directed breakpoint cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_lut_interp_ctrl;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int AW = $clog2(N);

    logic clk;
    logic rst_n;

    lut_interp_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    lut_interp_ctrl #(.DATA_WIDTH(DW), .NUM_POINTS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (bus.cfg_we),
        .cfg_addr    (bus.cfg_addr),
        .cfg_x       (bus.cfg_x),
        .cfg_y       (bus.cfg_y),
        .cfg_busy    (bus.cfg_busy),
        .in_valid    (bus.in_valid),
        .in_ready    (bus.in_ready),
        .in_x        (bus.in_x),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready),
        .out_y       (bus.out_y),
        .out_clamped (bus.out_clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    longint m_tx [N];
    longint m_ty [N];
    bit     m_busy, m_valid, m_clamp;
    longint m_y;
    int     m_cnt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_tx[i] = 0;
            m_ty[i] = 0;
        end
        m_busy = 0; m_valid = 0; m_clamp = 0; m_y = 0; m_cnt = 0;
    endtask

    // Clamp, pick the first segment whose right end exceeds xc (last one
    // otherwise), interpolate with truncation toward y0.
    function automatic void model_eval(input longint xin, output longint y,
                                       output bit cl, output int seg);
        longint xc, x0, x1, y0, y1;
        xc = xin; cl = 0;
        if (xin < m_tx[0]) begin xc = m_tx[0]; cl = 1; end
        else if (xin > m_tx[N-1]) begin xc = m_tx[N-1]; cl = 1; end
        seg = N - 2;
        for (int i = 0; i <= N - 2; i++) begin
            if (xc < m_tx[i+1]) begin seg = i; break; end
        end
        x0 = m_tx[seg]; x1 = m_tx[seg+1]; y0 = m_ty[seg]; y1 = m_ty[seg+1];
        if (x1 == x0) y = y0;
        else if (y1 >= y0) y = y0 + ((y1 - y0) * (xc - x0)) / (x1 - x0);
        else y = y0 - ((y0 - y1) * (xc - x0)) / (x1 - x0);
    endfunction

    task automatic model_step();
        longint y;
        bit     cl;
        int     s;
        if (!m_busy) begin
            if (bus.in_valid) begin
                model_eval(longint'(bus.in_x), y, cl, s);
                m_y = y; m_clamp = cl; m_cnt = s + 2; m_busy = 1; m_valid = 0;
            end
            // Applied after evaluation: the accepted query used the old table.
            if (bus.cfg_we) begin
                m_tx[bus.cfg_addr] = longint'(bus.cfg_x);
                m_ty[bus.cfg_addr] = longint'(bus.cfg_y);
            end
        end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end else if (bus.out_ready) begin
            m_busy = 0; m_valid = 0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("in_ready",  longint'(bus.in_ready),  longint'(!m_busy));
            chk("cfg_busy",  longint'(bus.cfg_busy),  longint'(m_busy));
            chk("out_valid", longint'(bus.out_valid), longint'(m_valid));
            if (m_valid) begin
                chk("out_y",       longint'(bus.out_y),       m_y);
                chk("out_clamped", longint'(bus.out_clamped), longint'(m_clamp));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input longint x, input longint y);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_x    = DW'(x);
        bus.cfg_y    = DW'(y);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic load_linear();
        for (int i = 0; i < N; i++) wr(i, 10 * i, 100 * i);
    endtask

    // Issue one query with out_ready high; check latency and result literally.
    task automatic query(input string tag, input longint x, input longint exp_y,
                         input bit exp_cl, input int exp_lat);
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = DW'(x);
        tick();
        bus.in_valid  = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".y"}, longint'(bus.out_y), exp_y);
        chk({tag, ".clamped"}, longint'(bus.out_clamped), longint'(exp_cl));
        tick();
    endtask

    task automatic random_phase(input int cycles);
        longint x;
        int     r;
        x = $urandom_range(0, 1000);
        for (int i = 0; i < N; i++) begin
            wr(i, x, $urandom_range(0, 65535));
            x += $urandom_range(1, 8000);
        end
        for (int c = 0; c < cycles; c++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       bus.in_x = DW'(m_tx[$urandom_range(0, N-1)]);
            else if (r == 3) bus.in_x = '0;
            else if (r == 4) bus.in_x = '1;
            else             bus.in_x = DW'($urandom_range(0, 65535));
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            bus.cfg_we    = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, N-1);
            bus.cfg_addr  = AW'(r);
            bus.cfg_x     = DW'(m_tx[r]);
            bus.cfg_y     = DW'($urandom_range(0, 65535));
            tick();
        end
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.out_ready = 1'b1;
        repeat (12) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_x = '0; bus.cfg_y = '0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.out_valid",   longint'(bus.out_valid),   0);
        chk("rst.out_y",       longint'(bus.out_y),       0);
        chk("rst.out_clamped", longint'(bus.out_clamped), 0);
        chk("rst.cfg_busy",    longint'(bus.cfg_busy),    0);
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready", longint'(bus.in_ready), 1);
        cmp_en = 1'b1;

        load_linear();
        query("q15",  15,  150, 0, 3);
        query("q0",   0,   0,   0, 2);
        query("q200", 200, 700, 1, 8);
        query("q70",  70,  700, 0, 8);

        // Result held under back-pressure; writes dropped while busy.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 16'd65;
        tick();
        bus.in_valid  = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin tick(); n++; end
        chk("q65.latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_x = 16'd5; bus.cfg_y = 16'd999;
            tick();
            chk("hold.out_valid", longint'(bus.out_valid), 1);
            chk("hold.out_y",     longint'(bus.out_y),     650);
            chk("hold.in_ready",  longint'(bus.in_ready),  0);
        end
        bus.cfg_we = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        query("q0_after_hold", 0, 0, 0, 2);

        // Rewrite entry 1, then entries 1 and 2 sharing x=10.
        wr(1, 10, 1000);
        query("q5", 5, 500, 0, 2);
        wr(2, 10, 1000);
        query("q10_dup", 10, 1000, 0, 4);
        wr(1, 10, 100);
        wr(2, 20, 200);

        // Write on the accept edge: query sees old entry, next query new.
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_x = 16'd20; bus.cfg_y = 16'd5000;
        query("q25_simul", 25, 250, 0, 4);
        bus.cfg_we = 1'b0;
        query("q20_new", 20, 5000, 0, 4);
        wr(2, 20, 200);

        // Falling segment: 20..30 maps 200..50.
        wr(3, 30, 50);
        query("q24_desc", 24, 140, 0, 4);
        wr(3, 30, 300);

        // Zero-width last segment.
        wr(7, 60, 777);
        query("q100_degen", 100, 600, 1, 8);
        wr(7, 70, 700);

        // Reset in the middle of SEARCH.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 16'd55;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.out_valid", longint'(bus.out_valid), 0);
        chk("midrst.cfg_busy",  longint'(bus.cfg_busy),  0);
        chk("midrst.out_y",     longint'(bus.out_y),     0);
        #1 rst_n = 1'b1;
        tick();
        chk("midrst.in_ready", longint'(bus.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        chk("midrst.no_out_valid", seen, 0);
        query("q0_zero_tbl",   0,   0, 0, 8);
        query("q200_zero_tbl", 200, 0, 1, 8);

        random_phase(300);
        random_phase(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
